mac_dot_ctrl: RTL and testbench
===============================

Name: mac_dot_ctrl

Overview:
Sequencer that computes one dot product per command, acc = bias + sum(a_i*b_i), i = 0..len-1, on a single shared MAC instance.
- Sits between the operand-fetch logic and a MAC instance (INT8 or FP32) in the GEMM tile; the MAC itself is instantiated outside this block.
- Precision-agnostic: treats the accumulator as opaque bits and feeds the MAC result back as op_C.
- Issues one term at a time and waits for the MAC pipeline to drain before the next issue, so there is no accumulation hazard.

Parameters:
DATA_WIDTH, 32, width of each operand a/b (matches MAC_INPUT_WIDTH).
ACC_WIDTH, 32, width of bias, accumulator and MAC result (matches MAC_ACC_WIDTH = MAC_OUTPUT_WIDTH).
MAC_LATENCY, 3, cycles from MAC input to res_Z; must equal the attached MAC's ADDER_LATENCY+MULT_LATENCY+1.
LEN_WIDTH, 8, width of the term count.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_len  in  LEN_WIDTH  number of terms (0 allowed)
cmd_bias  in  ACC_WIDTH  initial accumulator value
in_valid  in  1  operand pair offered
in_ready  out  1  operand pair consumed when both high
in_a  in  DATA_WIDTH  operand A
in_b  in  DATA_WIDTH  operand B
mac_a  out  DATA_WIDTH  to MAC op_A (registered)
mac_b  out  DATA_WIDTH  to MAC op_B (registered)
mac_c  out  ACC_WIDTH  to MAC op_C (registered)
mac_in_valid  out  1  high in the cycle the mac_* inputs carry a live term
mac_z  in  ACC_WIDTH  from MAC res_Z
res_valid  out  1  result available
res_ready  in  1  result consumed when both high
res_data  out  ACC_WIDTH  final accumulator
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it is sampled only at the clk edge.
- After the reset edge: state=IDLE, cmd_ready=1, in_ready=0, res_valid=0, busy=0, mac_in_valid=0; mac_a/mac_b/mac_c/res_data/acc/counters=0.
- All handshake outputs decode from registered state; no combinational path from any input to any output.
- IDLE:
  - cmd_ready=1.
  - On cmd handshake: acc<=cmd_bias, remaining<=cmd_len.
  - Next state is DONE if cmd_len==0, else ISSUE.
- ISSUE:
  - in_ready=1.
  - On in handshake: mac_a<=in_a, mac_b<=in_b, mac_c<=acc, mac_in_valid<=1 (for one cycle), remaining<=remaining-1, wcnt<=MAC_LATENCY, go to WAIT.
  - No handshake: stay in ISSUE. in_valid gaps are legal.
- WAIT:
  - in_ready=0.
  - The cycle after the handshake, mac_a/mac_b are live; from the next cycle they are driven to 0 and mac_in_valid=0. mac_c holds.
  - wcnt decrements each cycle. When wcnt==0: acc<=mac_z. This is cycle t+1+MAC_LATENCY for a handshake in cycle t.
  - Same edge: go to ISSUE if remaining!=0, else DONE.
- Timing: issue spacing is MAC_LATENCY+2 cycles, i.e. the in_ready high cycles are MAC_LATENCY+2 apart when in_valid is held high.
- DONE:
  - res_valid=1, res_data=acc, held stable until res_ready.
  - On res handshake: go to IDLE.
  - cmd_ready is 0 in DONE; the next command can be accepted no earlier than the cycle after the result handshake.
- len==0: res_valid rises in the cycle after the cmd handshake with res_data=cmd_bias; the MAC is untouched.
- Operand pairs beyond len are not consumed. in_valid outside ISSUE is ignored.
- Reset mid-operation: rst in any state returns to IDLE with all values as listed above. An in-flight mac_z is ignored (IDLE never samples mac_z). No partial result is emitted.
- mac_z is sampled only at wcnt==0 in WAIT; any other value is don't-care.
- Arithmetic: no width growth and no saturation here. Overflow/rounding is whatever the MAC produces.

Decomposition:
- Shared package mac_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} mac_ctrl_state_t;
  - the wait-counter width constant, computed as clog2(MAC_LATENCY+1).
- No sub-module: single FSM plus two counters (remaining, wcnt) and the acc/mac_* registers.
- The bench attaches a MAC instance (MAC_PRECISION=1 for integer checks) with matching latency.

Test Plan:
1. INT, MAC_LATENCY=3: cmd len=3, bias=10; pairs (2,3),(4,5),(-1,6), in_valid always high. Expect res_data=30, in_ready handshakes exactly 5 cycles apart, res_valid 4 cycles after the last MAC input cycle.
2. cmd len=0, bias=7. Expect res_valid the cycle after cmd acceptance with res_data=7; mac_in_valid never asserted; in_ready never asserted.
3. len=2, bias=0; pairs (3,3),(2,-5); res_ready held low 4 cycles. Expect res_data=-1 held stable throughout, cmd_ready=0 until the handshake, IDLE the next cycle.
4. len=2; in_valid dropped for 6 cycles before the second pair. Expect in_ready to stay high while waiting, the second issue on the first in_valid cycle, and a correct sum.
5. rst pulsed while in WAIT of term 1 of len=4. Expect next-cycle cmd_ready=1, res_valid=0, acc=0. A new cmd len=1, bias=5, pair (2,2) yields 9.
6. Back-to-back: cmd len=1 (bias 1, pair (1,1)) and cmd len=1 (bias 0, pair (7,7)) with cmd_valid held high. Expect results 2 then 49, and the second cmd accepted the cycle after the first result handshake.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared types and helpers for the dot-product MAC sequencer.
package mac_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} mac_ctrl_state_t;

  localparam int unsigned MAC_LATENCY_DEF = 3;

  // Counter width able to hold the value lat; never narrower than one bit.
  function automatic int unsigned wcnt_width(input int unsigned lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

  localparam int unsigned WCNT_WIDTH = wcnt_width(MAC_LATENCY_DEF);

endpackage

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer: acc = bias + sum(a_i*b_i), one term at a time on a shared
// external MAC, waiting for the MAC pipeline to drain before each next issue.
module mac_dot_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ACC_WIDTH   = 32,
  parameter int unsigned MAC_LATENCY = 3,
  parameter int unsigned LEN_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [ACC_WIDTH-1:0]  cmd_bias,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic [ACC_WIDTH-1:0]  mac_c,
  output logic                  mac_in_valid,
  input  logic [ACC_WIDTH-1:0]  mac_z,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  busy
);

  localparam int unsigned WCNT_W = wcnt_width(MAC_LATENCY);

  mac_ctrl_state_t        r_state;
  mac_ctrl_state_t        w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_remaining;
  logic [WCNT_W-1:0]      r_wcnt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [DATA_WIDTH-1:0]  r_mac_a;
  logic [DATA_WIDTH-1:0]  r_mac_b;
  logic [ACC_WIDTH-1:0]   r_mac_c;
  logic                   r_mac_in_valid;
  logic                   r_cmd_ready;
  logic                   r_in_ready;
  logic                   r_res_valid;
  logic                   r_busy;
  logic                   w_cmd_hs;
  logic                   w_in_hs;
  logic                   w_wait_done;

  assign w_cmd_hs    = (r_state == IDLE)  && cmd_valid;
  assign w_in_hs     = (r_state == ISSUE) && in_valid;
  assign w_wait_done = (r_state == WAIT)  && (r_wcnt == '0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (cmd_valid) w_state_nxt = (cmd_len == '0) ? DONE : ISSUE;
      ISSUE:   if (in_valid)  w_state_nxt = WAIT;
      WAIT:    if (r_wcnt == '0) w_state_nxt = (r_remaining != '0) ? ISSUE : DONE;
      DONE:    if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered copies of the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == IDLE);
      r_in_ready  <= (w_state_nxt == ISSUE);
      r_res_valid <= (w_state_nxt == DONE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  // Operands are live for exactly one cycle; op_C holds the issued accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc          <= '0;
      r_remaining    <= '0;
      r_wcnt         <= '0;
      r_mac_a        <= '0;
      r_mac_b        <= '0;
      r_mac_c        <= '0;
      r_mac_in_valid <= 1'b0;
    end else begin
      r_mac_a        <= '0;
      r_mac_b        <= '0;
      r_mac_in_valid <= 1'b0;
      if (w_cmd_hs) begin
        r_acc       <= cmd_bias;
        r_remaining <= cmd_len;
      end
      if (w_in_hs) begin
        r_mac_a        <= in_a;
        r_mac_b        <= in_b;
        r_mac_c        <= r_acc;
        r_mac_in_valid <= 1'b1;
        r_remaining    <= r_remaining - LEN_WIDTH'(1);
        r_wcnt         <= WCNT_W'(MAC_LATENCY);
      end
      if (w_wait_done) begin
        r_acc <= mac_z;
      end else if (r_state == WAIT) begin
        r_wcnt <= r_wcnt - WCNT_W'(1);
      end
    end
  end

  assign cmd_ready    = r_cmd_ready;
  assign in_ready     = r_in_ready;
  assign res_valid    = r_res_valid;
  assign busy         = r_busy;
  assign res_data     = r_acc;
  assign mac_a        = r_mac_a;
  assign mac_b        = r_mac_b;
  assign mac_c        = r_mac_c;
  assign mac_in_valid = r_mac_in_valid;

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Directed bench for mac_dot_ctrl with an integer MAC stand-in of matching latency.
module tb_mac_dot_ctrl;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 3;
  localparam int unsigned LW  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] cmd_bias;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic [DW-1:0] mac_a, mac_b;
  logic [AW-1:0] mac_c, mac_z;
  logic          mac_in_valid;
  logic          res_valid, res_ready;
  logic [AW-1:0] res_data;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mac_dot_ctrl #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAC_LATENCY(LAT), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_in_valid(mac_in_valid),
    .mac_z(mac_z),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Integer MAC: res_Z = A*B + C, LAT register stages after the input cycle.
  logic [AW-1:0] p [LAT];
  always @(posedge clk) begin
    p[0] <= mac_a * mac_b + mac_c;
    for (int i = 1; i < LAT; i++) p[i] <= p[i-1];
  end
  assign mac_z = p[LAT-1];

  // Observations gathered by do_dot.
  logic [31:0] va [4];
  logic [31:0] vb [4];
  int          hs [4];
  logic [31:0] o_res;
  int n_hs, n_mac, n_ir, n_stale, n_unstab;
  int cmd_c, res_c, last_mac, res_hs;

  task automatic do_dot(input int len, input logic [31:0] bias, input int gap_idx,
                        input int gap_len, input int hold, input bit keep_cmd, input bit extra);
    int idx, gap_left, held;
    bit seen, done;
    idx = 0; gap_left = gap_len; held = 0; seen = 0; done = 0;
    n_hs = 0; n_mac = 0; n_ir = 0; n_stale = 0; n_unstab = 0;
    cmd_c = -1; res_c = -1; last_mac = -1; res_hs = -1; o_res = '0;
    for (int g = 0; g < 30; g++) begin
      @(negedge clk);
      res_ready = 1'b0;
      cmd_valid = 1'b1;
      cmd_len   = LW'(len);
      cmd_bias  = bias;
      if (cmd_ready === 1'b1) begin
        cmd_c = cyc;
        break;
      end
    end
    if (cmd_c < 0) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout got none exp cmd_ready");
      return;
    end
    for (int g = 0; g < 200 && !done; g++) begin
      @(negedge clk);
      if (!keep_cmd) cmd_valid = 1'b0;
      if (mac_in_valid === 1'b1) begin
        n_mac++; last_mac = cyc;
      end else if (mac_a !== '0 || mac_b !== '0) begin
        n_stale++;
      end
      if (in_ready === 1'b1) n_ir++;
      if (idx < len) begin
        in_a = va[idx]; in_b = vb[idx];
        if (idx == gap_idx && gap_left > 0 && in_ready === 1'b1) begin
          in_valid = 1'b0; gap_left--;
        end else begin
          in_valid = 1'b1;
        end
      end else begin
        in_valid = extra; in_a = 32'hdead; in_b = 32'hbeef;
      end
      if (in_valid && in_ready === 1'b1) begin
        if (n_hs < 4) hs[n_hs] = cyc;
        n_hs++;
        if (idx < len) idx++;
      end
      if (res_valid === 1'b1) begin
        if (!seen) begin
          seen = 1; o_res = res_data; res_c = cyc;
        end else if (res_data !== o_res) begin
          n_unstab++;
        end
        if (cmd_ready !== 1'b0) n_unstab++;
        if (held >= hold) begin
          res_ready = 1'b1; res_hs = cyc; done = 1;
        end else begin
          held++;
        end
      end else if (seen) begin
        n_unstab++;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL result_timeout got none exp res_valid");
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_bias = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b exp 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (mac_in_valid !== 1'b0) begin errors++; $display("FAIL rst_mac_in_valid got %b exp 0", mac_in_valid); end
    checks++; if ({mac_a, mac_b, mac_c, res_data} !== '0) begin
      errors++; $display("FAIL rst_data got %h/%h/%h/%h exp 0", mac_a, mac_b, mac_c, res_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    va[0] = 32'd2; vb[0] = 32'd3;
    va[1] = 32'd4; vb[1] = 32'd5;
    va[2] = -32'sd1; vb[2] = 32'd6;
    do_dot(3, 32'd10, -1, 0, 0, 1'b0, 1'b1);
    checks++; if (o_res !== 32'd30) begin errors++; $display("FAIL basic_result got %0d exp 30", $signed(o_res)); end
    checks++; if (n_hs != 3) begin errors++; $display("FAIL basic_hs_count got %0d exp 3", n_hs); end
    checks++; if (hs[0] != cmd_c + 1) begin errors++; $display("FAIL basic_first_issue got %0d exp %0d", hs[0], cmd_c + 1); end
    checks++; if (hs[1] - hs[0] != 5) begin errors++; $display("FAIL basic_spacing01 got %0d exp 5", hs[1] - hs[0]); end
    checks++; if (hs[2] - hs[1] != 5) begin errors++; $display("FAIL basic_spacing12 got %0d exp 5", hs[2] - hs[1]); end
    checks++; if (n_mac != 3) begin errors++; $display("FAIL basic_mac_pulses got %0d exp 3", n_mac); end
    checks++; if (last_mac != hs[2] + 1) begin errors++; $display("FAIL basic_mac_cycle got %0d exp %0d", last_mac, hs[2] + 1); end
    checks++; if (res_c - last_mac != 4) begin errors++; $display("FAIL basic_res_latency got %0d exp 4", res_c - last_mac); end
    checks++; if (n_stale != 0) begin errors++; $display("FAIL basic_stale_operands got %0d exp 0", n_stale); end
  endtask

  task automatic test_len_zero();
    do_dot(0, 32'd7, -1, 0, 0, 1'b0, 1'b1);
    checks++; if (o_res !== 32'd7) begin errors++; $display("FAIL len0_result got %0d exp 7", o_res); end
    checks++; if (res_c != cmd_c + 1) begin errors++; $display("FAIL len0_latency got %0d exp %0d", res_c, cmd_c + 1); end
    checks++; if (n_mac != 0) begin errors++; $display("FAIL len0_mac_pulses got %0d exp 0", n_mac); end
    checks++; if (n_ir != 0) begin errors++; $display("FAIL len0_in_ready got %0d exp 0", n_ir); end
  endtask

  task automatic test_backpressure();
    va[0] = 32'd3; vb[0] = 32'd3;
    va[1] = 32'd2; vb[1] = -32'sd5;
    do_dot(2, 32'd0, -1, 0, 4, 1'b0, 1'b0);
    checks++; if (o_res !== 32'hFFFF_FFFF) begin errors++; $display("FAIL bp_result got %h exp ffffffff", o_res); end
    checks++; if (n_unstab != 0) begin errors++; $display("FAIL bp_hold_stable got %0d exp 0", n_unstab); end
    checks++; if (res_hs - res_c != 4) begin errors++; $display("FAIL bp_hold_len got %0d exp 4", res_hs - res_c); end
    @(negedge clk);
    res_ready = 1'b0;
    checks++; if ({cmd_ready, res_valid, busy} !== 3'b100) begin
      errors++; $display("FAIL bp_idle_after got %b exp 100", {cmd_ready, res_valid, busy});
    end
  endtask

  task automatic test_in_gap();
    va[0] = 32'd4; vb[0] = -32'sd3;
    va[1] = 32'd5; vb[1] = 32'd6;
    do_dot(2, 32'd2, 1, 6, 0, 1'b0, 1'b0);
    checks++; if (o_res !== 32'd20) begin errors++; $display("FAIL gap_result got %0d exp 20", $signed(o_res)); end
    checks++; if (hs[1] - hs[0] != 11) begin errors++; $display("FAIL gap_spacing got %0d exp 11", hs[1] - hs[0]); end
    checks++; if (n_ir != 8) begin errors++; $display("FAIL gap_in_ready_cycles got %0d exp 8", n_ir); end
  endtask

  task automatic test_mid_reset();
    int got, bad;
    got = 0; bad = 0;
    @(negedge clk);
    res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_len = LW'(4); cmd_bias = 32'd100;
    in_valid = 1'b1; in_a = 32'd9; in_b = 32'd9;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (cmd_ready === 1'b0) cmd_valid = 1'b0;
      if (mac_in_valid === 1'b1) begin got = 1; break; end
    end
    checks++; if (got != 1) begin errors++; $display("FAIL mrst_first_issue got %0d exp 1", got); end
    in_valid = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({cmd_ready, res_valid, busy, in_ready, mac_in_valid} !== 5'b10000) begin
      errors++; $display("FAIL mrst_flags got %b exp 10000", {cmd_ready, res_valid, busy, in_ready, mac_in_valid});
    end
    checks++; if ({res_data, mac_c} !== '0) begin errors++; $display("FAIL mrst_acc got %h/%h exp 0", res_data, mac_c); end
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mrst_quiet got %0d exp 0", bad); end
    va[0] = 32'd2; vb[0] = 32'd2;
    do_dot(1, 32'd5, -1, 0, 0, 1'b0, 1'b0);
    checks++; if (o_res !== 32'd9) begin errors++; $display("FAIL mrst_new_result got %0d exp 9", o_res); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1;
    int rh1;
    va[0] = 32'd1; vb[0] = 32'd1;
    do_dot(1, 32'd1, -1, 0, 0, 1'b1, 1'b0);
    r1 = o_res; rh1 = res_hs;
    va[0] = 32'd7; vb[0] = 32'd7;
    do_dot(1, 32'd0, -1, 0, 0, 1'b1, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0; res_ready = 1'b0;
    checks++; if (r1 !== 32'd2) begin errors++; $display("FAIL b2b_first got %0d exp 2", r1); end
    checks++; if (o_res !== 32'd49) begin errors++; $display("FAIL b2b_second got %0d exp 49", o_res); end
    checks++; if (cmd_c != rh1 + 1) begin errors++; $display("FAIL b2b_accept_cycle got %0d exp %0d", cmd_c, rh1 + 1); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_backpressure();
    test_in_gap();
    test_mid_reset();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
